// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//
// Target side of the CPU load/store request interface. One word read or
// write is accepted per request strobe while idle. A countdown models a
// fixed access latency, then a single-cycle acknowledge is returned
// together with the read data and an error flag. Misaligned and
// out-of-range requests are flagged and never touch the storage array.
//
// Parameters
//   DEPTH_WORDS : number of 32-bit words in the array (power of two, >= 4)
//   LATENCY     : clock edges from request acceptance to ack_o (>= 1)
//
// Ports
//   clk_i     in   1  clock, rising edge
//   rst_i     in   1  asynchronous reset, active-high
//   req_i     in   1  request strobe, sampled only while busy_o is low
//   we_i      in   1  1 = write, 0 = read, sampled with req_i
//   addr_i    in  32  byte address, sampled with req_i
//   wdata_i   in  32  write data, sampled with req_i
//   rdata_o   out 32  read data, valid with ack_o and held until next ack
//   ack_o     out  1  one-cycle completion pulse
//   err_o     out  1  error status of the completed request, held like rdata_o
//   busy_o    out  1  high from the cycle after acceptance through the ack cycle
// ---------------------------------------------------------------------------
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        ack_o,
    output logic        err_o,
    output logic        busy_o
);

    localparam int IDXW = $clog2(DEPTH_WORDS);
    localparam int CNTW = (LATENCY > 1) ? $clog2(LATENCY) + 1 : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t            r_state;
    logic [CNTW-1:0]   r_count;
    logic              r_we;
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              r_ack;
    logic              r_err;
    logic              r_busy;

    logic [31:0]       r_mem [DEPTH_WORDS];

    logic [31:0]       w_curAddr;
    logic              w_curWe;
    logic              w_misaligned;
    logic              w_outOfRange;
    logic              w_err;
    logic [IDXW-1:0]   w_curIdx;
    logic [IDXW-1:0]   w_ackIdx;
    logic              w_memWrite;

    // With LATENCY=1 the request completes on the very edge that accepts it,
    // before the latched copies exist, so the completion logic looks at the
    // live inputs while idle and at the latched request otherwise.
    always_comb begin
        w_curAddr = r_addr;
        w_curWe   = r_we;
        if (r_state == S_IDLE) begin
            w_curAddr = addr_i;
            w_curWe   = we_i;
        end
    end

    // Any address bit above the word index makes the request out of range,
    // which also keeps high addresses from aliasing onto low words.
    always_comb begin
        w_misaligned = (w_curAddr[1:0] != 2'b00);
        w_outOfRange = ((w_curAddr[31:2] >> IDXW) != 30'd0);
        w_err        = w_misaligned | w_outOfRange;
        w_curIdx     = w_curAddr[IDXW+1:2];
        w_ackIdx     = r_addr[IDXW+1:2];
    end

    // r_err already holds the check result for the transaction in ACK.
    assign w_memWrite = (r_state == S_ACK) && r_we && !r_err;

    // Request sequencer: IDLE accepts, WAIT counts down, ACK pulses once.
    // Completion results (error, read data) are registered on entry to ACK.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_i) begin
                        r_we    <= we_i;
                        r_addr  <= addr_i;
                        r_wdata <= wdata_i;
                        r_busy  <= 1'b1;
                        if (LATENCY == 1) begin
                            r_state <= S_ACK;
                            r_count <= '0;
                            r_ack   <= 1'b1;
                            r_err   <= w_err;
                            if (w_err) begin
                                r_rdata <= '0;
                            end else if (!w_curWe) begin
                                r_rdata <= r_mem[w_curIdx];
                            end
                        end else begin
                            r_state <= S_WAIT;
                            r_count <= CNTW'(LATENCY - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (r_count == CNTW'(1)) begin
                        r_state <= S_ACK;
                        r_count <= '0;
                        r_ack   <= 1'b1;
                        r_err   <= w_err;
                        if (w_err) begin
                            r_rdata <= '0;
                        end else if (!w_curWe) begin
                            r_rdata <= r_mem[w_curIdx];
                        end
                    end else begin
                        r_count <= r_count - CNTW'(1);
                    end
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Storage array has no reset. The write lands on the edge that ends the
    // ACK cycle; a reset during the transaction leaves r_state out of ACK,
    // so an aborted write never reaches the array.
    always_ff @(posedge clk_i) begin
        if (w_memWrite) begin
            r_mem[w_ackIdx] <= r_wdata;
        end
    end

    assign rdata_o = r_rdata;
    assign ack_o   = r_ack;
    assign err_o   = r_err;
    assign busy_o  = r_busy;

endmodule

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder
//
// Drives two responder instances, one with LATENCY=4 and one with LATENCY=1,
// both with 256 words. A plain array per instance holds the expected memory
// contents; expected error, read data and ack timing come from the address
// rules and the latency parameter directly.
// ---------------------------------------------------------------------------
module tb_data_mem_responder;

    localparam int DEPTH = 256;
    localparam int LAT0  = 4;
    localparam int LAT1  = 1;

    logic        clk_i;
    logic        rst_i;
    logic        req     [2];
    logic        we      [2];
    logic [31:0] addr    [2];
    logic [31:0] wdata   [2];
    logic [31:0] rdata   [2];
    logic        ack     [2];
    logic        err     [2];
    logic        busy    [2];

    logic [31:0] model   [2][DEPTH];

    int checks;
    int errors;
    int cyc;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT0)) dut0 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (req[0]),
        .we_i    (we[0]),
        .addr_i  (addr[0]),
        .wdata_i (wdata[0]),
        .rdata_o (rdata[0]),
        .ack_o   (ack[0]),
        .err_o   (err[0]),
        .busy_o  (busy[0])
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT1)) dut1 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (req[1]),
        .we_i    (we[1]),
        .addr_i  (addr[1]),
        .wdata_i (wdata[1]),
        .rdata_o (rdata[1]),
        .ack_o   (ack[1]),
        .err_o   (err[1]),
        .busy_o  (busy[1])
    );

    // Free-running clock and a cycle counter used to time acks.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction, started at a negedge and finished at the negedge of
    // the first idle cycle after the ack, so calls chain back-to-back.
    // With pulse set, a stray write of 0xFFFFFFFF to 0x24 is offered in the
    // first busy cycle and in the ack cycle; both must be ignored.
    task automatic applyStimulus(input int sel, input logic isWrite, input logic [31:0] a,
                                 input logic [31:0] d, input bit pulse, output int ackAt);
        int          lat;
        int          k;
        int          w;
        bit          seen;
        logic        expErr;
        logic [31:0] expData;
        lat     = (sel == 0) ? LAT0 : LAT1;
        expErr  = ((a % 4) != 0) || ((a / 4) >= DEPTH);
        w       = expErr ? 0 : int'(a / 4);
        expData = expErr ? 32'd0 : model[sel][w];
        req[sel]   = 1'b1;
        we[sel]    = isWrite;
        addr[sel]  = a;
        wdata[sel] = d;
        seen  = 1'b0;
        k     = 0;
        ackAt = -1;
        while (!seen && k < 20) begin
            @(negedge clk_i);
            k++;
            req[sel] = 1'b0;
            if (ack[sel]) begin
                seen  = 1'b1;
                ackAt = cyc;
            end else begin
                checkOutput("busy_wait", 32'(busy[sel]), 32'd1);
            end
            if (pulse && (k == 1 || seen)) begin
                req[sel]   = 1'b1;
                we[sel]    = 1'b1;
                addr[sel]  = 32'h24;
                wdata[sel] = 32'hFFFF_FFFF;
            end
        end
        checkOutput("ack_seen", 32'(seen), 32'd1);
        checkOutput("ack_latency", 32'(k), 32'(lat));
        checkOutput("busy_at_ack", 32'(busy[sel]), 32'd1);
        checkOutput("err", 32'(err[sel]), 32'(expErr));
        if (!isWrite) checkOutput("rdata", rdata[sel], expData);
        @(negedge clk_i);
        req[sel] = 1'b0;
        checkOutput("ack_single", 32'(ack[sel]), 32'd0);
        checkOutput("busy_idle", 32'(busy[sel]), 32'd0);
        checkOutput("err_hold", 32'(err[sel]), 32'(expErr));
        if (!isWrite) checkOutput("rdata_hold", rdata[sel], expData);
        if (isWrite && !expErr) model[sel][w] = d;
    endtask

    task automatic backToBack(input int sel);
        int t0, t1, t2, lat;
        lat = (sel == 0) ? LAT0 : LAT1;
        applyStimulus(sel, 1'b1, 32'h40, 32'h0BAD_F00D ^ 32'(sel), 1'b0, t0);
        applyStimulus(sel, 1'b1, 32'h44, 32'h1357_9BDF ^ 32'(sel), 1'b0, t1);
        applyStimulus(sel, 1'b1, 32'h48, 32'h2468_ACE0 ^ 32'(sel), 1'b0, t2);
        checkOutput("b2b_gap1", 32'(t1 - t0), 32'(lat + 1));
        checkOutput("b2b_gap2", 32'(t2 - t1), 32'(lat + 1));
        applyStimulus(sel, 1'b0, 32'h40, 32'd0, 1'b0, t0);
        applyStimulus(sel, 1'b0, 32'h44, 32'd0, 1'b0, t0);
        applyStimulus(sel, 1'b0, 32'h48, 32'd0, 1'b0, t0);
    endtask

    initial begin
        int          t;
        bit          sawAck;
        logic [31:0] a;
        int          r;
        checks = 0;
        errors = 0;
        rst_i  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req[i]   = 1'b0;
            we[i]    = 1'b0;
            addr[i]  = '0;
            wdata[i] = '0;
        end

        // Reset values on both instances.
        repeat (2) @(negedge clk_i);
        for (int i = 0; i < 2; i++) begin
            checkOutput("reset_rdata", rdata[i], 32'd0);
            checkOutput("reset_ack", 32'(ack[i]), 32'd0);
            checkOutput("reset_err", 32'(err[i]), 32'd0);
            checkOutput("reset_busy", 32'(busy[i]), 32'd0);
        end
        rst_i = 1'b0;
        @(negedge clk_i);

        // Seed words 0..31 of both instances; word 12 (0x30) gets zero.
        for (int i = 0; i < 2; i++) begin
            for (int w = 0; w < 32; w++) begin
                applyStimulus(i, 1'b1, 32'(w * 4), (w == 12) ? 32'd0 : $urandom, 1'b0, t);
            end
        end

        // Directed cases on the LATENCY=4 instance.
        applyStimulus(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, t);
        applyStimulus(0, 1'b0, 32'h10, 32'd0, 1'b0, t);
        checkOutput("read_10_value", rdata[0], 32'hDEAD_BEEF);
        applyStimulus(0, 1'b0, 32'h12, 32'd0, 1'b0, t);
        applyStimulus(0, 1'b0, 32'h10, 32'd0, 1'b0, t);
        applyStimulus(0, 1'b1, 32'h400, 32'h1234_5678, 1'b0, t);
        applyStimulus(0, 1'b0, 32'h0, 32'd0, 1'b0, t);
        applyStimulus(0, 1'b1, 32'h20, 32'h5A5A_0F0F, 1'b1, t);
        applyStimulus(0, 1'b0, 32'h24, 32'd0, 1'b0, t);
        applyStimulus(0, 1'b0, 32'h20, 32'd0, 1'b0, t);

        // Reset in the middle of a write: the write and its ack must vanish.
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h30; wdata[0] = 32'hAAAA_5555;
        @(negedge clk_i);
        req[0] = 1'b0;
        @(negedge clk_i);
        checkOutput("abort_busy_before", 32'(busy[0]), 32'd1);
        rst_i = 1'b1;
        #1;
        checkOutput("abort_busy", 32'(busy[0]), 32'd0);
        checkOutput("abort_ack", 32'(ack[0]), 32'd0);
        checkOutput("abort_rdata", rdata[0], 32'd0);
        checkOutput("abort_err", 32'(err[0]), 32'd0);
        @(negedge clk_i);
        rst_i  = 1'b0;
        sawAck = 1'b0;
        repeat (6) begin
            @(negedge clk_i);
            if (ack[0]) sawAck = 1'b1;
        end
        checkOutput("abort_no_ack", 32'(sawAck), 32'd0);
        applyStimulus(0, 1'b0, 32'h30, 32'd0, 1'b0, t);
        checkOutput("abort_not_written", 32'(rdata[0] != 32'hAAAA_5555), 32'd1);

        backToBack(0);
        backToBack(1);

        // Randomised traffic: mostly valid words, some misaligned, some out of range.
        for (int i = 0; i < 2; i++) begin
            for (int n = 0; n < 40; n++) begin
                r = int'($urandom_range(9, 0));
                if (r < 7) a = 32'($urandom_range(31, 0)) * 4;
                else if (r < 9) a = 32'($urandom_range(31, 0)) * 4 + 32'($urandom_range(3, 1));
                else a = ($urandom | 32'h400) & 32'hFFFF_FFFC;
                applyStimulus(i, 1'($urandom_range(1, 0)), a, $urandom, 1'b0, t);
                repeat ($urandom_range(2, 0)) @(negedge clk_i);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
